// File: rtl/dmem_block_responder_if.sv
// Request/response bundle between the D-cache miss FSM (master) and the
// block-level data memory responder (slave).
interface dmem_block_responder_if #(
  parameter int BLOCK_BITS   = 128,
  parameter int BLOCK_ADDR_W = 28
);
  logic                    memRen;
  logic                    memWen;
  logic [BLOCK_ADDR_W-1:0] BlockAddr;
  logic [BLOCK_BITS-1:0]   memDin;
  logic                    memReadReady;
  logic                    memWriteDone;
  logic [BLOCK_BITS-1:0]   memDout;
  logic                    busy;
  logic                    proto_err;

  modport master (
    output memRen, memWen, BlockAddr, memDin,
    input  memReadReady, memWriteDone, memDout, busy, proto_err
  );

  modport slave (
    input  memRen, memWen, BlockAddr, memDin,
    output memReadReady, memWriteDone, memDout, busy, proto_err
  );
endinterface

// File: rtl/dmem_block_responder.sv
// Block-granular data memory answering D-cache refills (reads) and
// writebacks (writes) with a fixed, parameterised latency. Every request
// walks IDLE -> RBUSY/WBUSY -> ACK -> IDLE, so a new request can be taken
// one cycle after the completion pulse.
module dmem_block_responder #(
  parameter int BLOCK_BITS   = 128,
  parameter int BLOCK_ADDR_W = 28,
  parameter int DEPTH_LOG2   = 8,
  parameter int READ_LAT     = 4,
  parameter int WRITE_LAT    = 4
) (
  input logic                   clk,
  input logic                   rst,
  dmem_block_responder_if.slave bus
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RBUSY,
    WBUSY,
    ACK
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [BLOCK_BITS-1:0]   wdata_q;
  logic [BLOCK_BITS-1:0]   dout_q;
  logic                    readReady_q;
  logic                    writeDone_q;
  logic                    busy_q;
  logic                    protoErr_q;

  logic [BLOCK_BITS-1:0]   mem [DEPTH];

  logic                    commitWr;
  logic [DEPTH_LOG2-1:0]   reqIdx;
  logic                    unusedAddrBits;

  // Upper address bits alias onto the same entry, so they are dropped here.
  assign reqIdx         = bus.BlockAddr[DEPTH_LOG2-1:0];
  assign unusedAddrBits = ^bus.BlockAddr[BLOCK_ADDR_W-1:DEPTH_LOG2];

  // A write lands in the array on the same edge that raises memWriteDone,
  // so a read started after the pulse already sees the new block.
  assign commitWr = (state_q == WBUSY) && (cnt_q == '0);

  // Storage is deliberately not reset; an aborted write never reaches WBUSY
  // with a zero count again, so reset discards it.
  always_ff @(posedge clk) begin
    if (commitWr) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Request sequencer: accepts one op in IDLE, counts down the latency,
  // fires a single-cycle completion pulse in ACK, then returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      dout_q      <= '0;
      readReady_q <= 1'b0;
      writeDone_q <= 1'b0;
      busy_q      <= 1'b0;
      protoErr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.memRen && bus.memWen) begin
            protoErr_q <= 1'b1;
          end else if (bus.memRen) begin
            idx_q   <= reqIdx;
            cnt_q   <= RD_INIT;
            busy_q  <= 1'b1;
            state_q <= RBUSY;
          end else if (bus.memWen) begin
            idx_q   <= reqIdx;
            wdata_q <= bus.memDin;
            cnt_q   <= WR_INIT;
            busy_q  <= 1'b1;
            state_q <= WBUSY;
          end
        end
        RBUSY: begin
          if (cnt_q == '0) begin
            dout_q      <= mem[idx_q];
            readReady_q <= 1'b1;
            state_q     <= ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WBUSY: begin
          if (cnt_q == '0) begin
            writeDone_q <= 1'b1;
            state_q     <= ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          readReady_q <= 1'b0;
          writeDone_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.memReadReady = readReady_q;
  assign bus.memWriteDone = writeDone_q;
  assign bus.memDout      = dout_q;
  assign bus.busy         = busy_q;
  assign bus.proto_err    = protoErr_q;

endmodule
